chacha20_core: RTL and testbench

//   ChaCha20 block function (20 rounds, 512-bit keystream block) used as the nonce/blinding-k source for ECDSA signing.

---
 rtl/chacha20_pkg.sv | 24 ++
 rtl/chacha_quarter_round.sv | 35 +++
 rtl/chacha20_core.sv | 124 ++++++++++++
 tb/tb_chacha20_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: constant words, word type, FSM encoding, rotate helper.
package chacha20_pkg;

    typedef logic [31:0] word_t;

    localparam word_t C0 = 32'h61707865;
    localparam word_t C1 = 32'h3320646e;
    localparam word_t C2 = 32'h79622d32;
    localparam word_t C3 = 32'h6b206574;

    localparam int ROUNDS_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic word_t rotl(input word_t v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_quarter_round
    import chacha20_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  word_t c,
    input  word_t d,
    output word_t a_out,
    output word_t b_out,
    output word_t c_out,
    output word_t d_out
);

    word_t a1, b1, c1, d1;
    word_t a2, b2, c2, d2;

    // Two add/xor/rotate half-steps, exactly as the ChaCha quarter-round sequence.
    always_comb begin
        a1 = a + b;
        d1 = rotl(d ^ a1, 16);
        c1 = c + d1;
        b1 = rotl(b ^ c1, 12);
        a2 = a1 + b1;
        d2 = rotl(d1 ^ a2, 8);
        c2 = c1 + d2;
        b2 = rotl(b1 ^ c2, 7);
    end

    assign a_out = a2;
    assign b_out = b2;
    assign c_out = c2;
    assign d_out = d2;

endmodule

// File: rtl/chacha20_core.sv
// Iterative ChaCha20 block function: one double-quarter-round layer per clock,
// Reset doubles as the load/start strobe, result held until the next Reset.
module chacha20_core
    import chacha20_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic [255:0] key,
    input  logic [127:0] nonce,
    output logic [511:0] stream,
    output logic         Done
);

    word_t       x     [16];
    word_t       s     [16];
    word_t       init  [16];
    word_t       x_next[16];
    word_t       qa[4], qb[4], qc[4], qd[4];
    word_t       ra[4], rb[4], rc[4], rd[4];
    logic [4:0]  cnt;
    state_t      state, state_next;
    logic        odd;

    assign odd = cnt[0];

    // Initial state: constants, key words, counter/nonce words.
    always_comb begin
        init[0] = C0;
        init[1] = C1;
        init[2] = C2;
        init[3] = C3;
        for (int k = 0; k < 8; k++) init[4 + k]  = key[32*k +: 32];
        for (int k = 0; k < 4; k++) init[12 + k] = nonce[32*k +: 32];
    end

    // Operand selection: columns on even rounds, diagonals on odd rounds.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            qa[i] = x[i];
            if (!odd) begin
                qb[i] = x[4 + i];
                qc[i] = x[8 + i];
                qd[i] = x[12 + i];
            end else begin
                qb[i] = x[4 + ((i + 1) % 4)];
                qc[i] = x[8 + ((i + 2) % 4)];
                qd[i] = x[12 + ((i + 3) % 4)];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_quarter_round u_qr (
            .a     (qa[g]),
            .b     (qb[g]),
            .c     (qc[g]),
            .d     (qd[g]),
            .a_out (ra[g]),
            .b_out (rb[g]),
            .c_out (rc[g]),
            .d_out (rd[g])
        );
    end

    // Write quarter-round results back to the lanes they were taken from.
    always_comb begin
        x_next = x;
        for (int i = 0; i < 4; i++) begin
            x_next[i] = ra[i];
            if (!odd) begin
                x_next[4 + i]  = rb[i];
                x_next[8 + i]  = rc[i];
                x_next[12 + i] = rd[i];
            end else begin
                x_next[4 + ((i + 1) % 4)]  = rb[i];
                x_next[8 + ((i + 2) % 4)]  = rc[i];
                x_next[12 + ((i + 3) % 4)] = rd[i];
            end
        end
    end

    // FSM state register; Reset forces LOAD from any state.
    always_ff @(posedge clk) begin
        if (Reset) state <= ST_LOAD;
        else       state <= state_next;
    end

    // Next-state: LOAD performs round 0, last round hands over to FINAL, DONE is terminal.
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD, ST_ROUND: state_next = (cnt == 5'(ROUNDS - 1)) ? ST_FINAL : ST_ROUND;
            ST_FINAL:          state_next = ST_DONE;
            ST_DONE:           state_next = ST_DONE;
            default:           state_next = ST_LOAD;
        endcase
    end

    // Datapath: load on Reset, iterate rounds, add initial state once at the end.
    always_ff @(posedge clk) begin
        if (Reset) begin
            x      <= init;
            s      <= init;
            cnt    <= '0;
            Done   <= 1'b0;
            stream <= '0;
        end else begin
            case (state)
                ST_LOAD, ST_ROUND: begin
                    x   <= x_next;
                    cnt <= cnt + 5'd1;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 16; i++) stream[32*i +: 32] <= x[i] + s[i];
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_core.sv
// Scoreboard bench for chacha20_core: stimulus queues expected blocks, a
// monitor compares them whenever Done rises.
module tb_chacha20_core;

    logic         clk = 1'b0;
    logic         Reset = 1'b0;
    logic [255:0] key = '0;
    logic [127:0] nonce = '0;
    logic [511:0] stream;
    logic         Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] w0, w1, w2, w3, w15;
        bit          full;
    } exp_t;

    exp_t exp_q[$];

    logic [255:0] rfc_key;
    logic [127:0] rfc_nonce;

    chacha20_core dut (
        .clk    (clk),
        .Reset  (Reset),
        .key    (key),
        .nonce  (nonce),
        .stream (stream),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic exp_t rfc_exp(input string name);
        exp_t e;
        e.name = name;
        e.w0 = 32'he4e7f110; e.w1 = 32'h15593bd1; e.w2 = 32'h1fdd0f50;
        e.w3 = 32'hc47120a3; e.w15 = 32'h4e3c50a2; e.full = 1'b1;
        return e;
    endfunction

    function automatic exp_t zero_exp(input string name);
        exp_t e;
        e.name = name;
        e.w0 = 32'hade0b876; e.w1 = '0; e.w2 = '0; e.w3 = '0; e.w15 = '0; e.full = 1'b0;
        return e;
    endfunction

    // Monitor: on each rising Done, pop one expected block and compare.
    logic done_q = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (Done && !done_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.name, "_w0"}, stream[31:0], e.w0);
                    if (e.full) begin
                        check({e.name, "_w1"}, stream[63:32], e.w1);
                        check({e.name, "_w2"}, stream[95:64], e.w2);
                        check({e.name, "_w3"}, stream[127:96], e.w3);
                        check({e.name, "_w15"}, stream[511:480], e.w15);
                    end
                end
            end
            done_q = Done;
        end
    end

    // Count edges after release; Done must be low through edge 20 and high at 21.
    task automatic run_latency(input string name);
        for (int n = 1; n <= 21; n++) begin
            @(posedge clk); #1;
            check($sformatf("%s_done_edge%0d", name, n), {31'd0, Done}, (n == 21) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001};

        // Test 1+3: RFC vector, single-cycle reset pulse, latency and hold.
        @(negedge clk);
        Reset = 1'b1; key = rfc_key; nonce = rfc_nonce;
        @(posedge clk); #1;
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_stream_w0", stream[31:0], 32'd0);
        check("reset_stream_w15", stream[511:480], 32'd0);
        exp_q.push_back(rfc_exp("rfc"));
        @(negedge clk); Reset = 1'b0;
        run_latency("rfc");
        repeat (110) @(posedge clk);
        #1;
        check("hold_done", {31'd0, Done}, 32'd1);
        check("hold_w0", stream[31:0], 32'he4e7f110);
        check("hold_w15", stream[511:480], 32'h4e3c50a2);

        // Test 2: all-zero key and nonce.
        @(negedge clk);
        Reset = 1'b1; key = '0; nonce = '0;
        @(posedge clk); #1;
        check("abort_from_done", {31'd0, Done}, 32'd0);
        exp_q.push_back(zero_exp("zero"));
        @(negedge clk); Reset = 1'b0;
        run_latency("zero");

        // Test 4: Reset held 5 cycles, key changes every cycle; last one wins.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            Reset = 1'b1;
            key = (c == 4) ? rfc_key : {8{32'(c * 32'h11111111 + 1)}};
            nonce = (c == 4) ? rfc_nonce : {4{32'(c + 7)}};
        end
        exp_q.push_back(rfc_exp("held"));
        @(negedge clk); Reset = 1'b0;
        run_latency("held");

        // Test 5: start zero-key run, abort at round 10 with RFC key.
        @(negedge clk);
        Reset = 1'b1; key = '0; nonce = '0;
        @(negedge clk); Reset = 1'b0;
        repeat (10) @(negedge clk);
        Reset = 1'b1; key = rfc_key; nonce = rfc_nonce;
        @(posedge clk); #1;
        check("midabort_done", {31'd0, Done}, 32'd0);
        check("midabort_stream", stream[31:0], 32'd0);
        exp_q.push_back(rfc_exp("abort"));
        @(negedge clk); Reset = 1'b0;
        run_latency("abort");

        // Test 6: inputs change after release; result unaffected.
        @(negedge clk);
        Reset = 1'b1; key = rfc_key; nonce = rfc_nonce;
        exp_q.push_back(rfc_exp("late"));
        @(negedge clk);
        Reset = 1'b0;
        key = '1; nonce = '1;
        @(negedge clk);
        key = '0; nonce = '0;
        for (int n = 2; n <= 21; n++) begin
            @(posedge clk); #1;
            check($sformatf("late_done_edge%0d", n), {31'd0, Done}, (n == 21) ? 32'd1 : 32'd0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
